// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch sequencer states
//   fq_entry_t    : one buffered fetch result {instruction word, its PC}
//   branch_target : redirect target = branch PC + (word offset * 4), modulo 2^64
package fetch_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  localparam int INST_W  = 32;
  localparam int PC_W    = 64;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int QDEPTH  = 2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fq_entry_t;

  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                    input logic [PC_W-1:0] word_off);
    return pc + (word_off << 2);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch -> decode instruction handshake.
//   inst / inst_pc / opcode : head instruction, its PC, and inst[31:21]
//   inst_valid / inst_ready : transfer happens on a cycle where both are high;
//                             the fetch side may drop inst_valid at any time
//                             (redirect), decode may drive inst_ready freely and
//                             it has no effect while inst_valid is low.
// master = fetch stage, slave = decode / control unit.
interface fetch_if;
  import fetch_pkg::*;

  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic [OPC_W-1:0]  opcode;
  logic              inst_valid;
  logic              inst_ready;

  modport master (output inst, inst_pc, opcode, inst_valid, input inst_ready);
  modport slave  (input inst, inst_pc, opcode, inst_valid, output inst_ready);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc} fetch results. Entry 0 is always the head,
// so a pop shifts entry 1 down.
//   push/wdata : append at tail        pop   : drop head
//   flush      : empty the queue (takes priority over push/pop)
//   head/count : current head entry and occupancy (0..2)
// The producer never pushes into a full queue unless it pops in the same cycle.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fq_entry_t  wdata,
  output fq_entry_t  head,
  output logic [1:0] count
);

  fq_entry_t  ent0_q, ent0_d;
  fq_entry_t  ent1_q, ent1_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = wdata;
          else                 ent1_d = wdata;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            ent0_d = wdata;
          end else begin
            ent0_d = ent1_q;
            ent1_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head  = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads a synchronous instruction ROM
// (data returns one cycle after imem_en), buffers results in a 2-entry queue
// and hands them to decode over fetch_if. A redirect (br_valid) reloads the PC,
// flushes the queue and squashes the read returning in that cycle.
//   clk, rst         : clock, synchronous active-high reset
//   imem_en/addr     : ROM read strobe and word address (pc[IMEM_AW+1:2])
//   imem_rdata       : ROM data for the read issued the previous cycle
//   br_valid/pc/off  : redirect pulse, branching PC, sign-extended word offset
//   dec              : fetch_if master (inst, inst_pc, opcode, valid/ready)
//   fault            : high while fetch is parked on an out-of-range PC
//   dbg_state        : current sequencer state
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          IMEM_AW  = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  input  logic               br_valid,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [PC_W-1:0]    br_offset,
  fetch_if.master            dec,
  output logic               fault,
  output fetch_state_e       dbg_state
);

  function automatic logic in_range(input logic [PC_W-1:0] a);
    return (a >> (IMEM_AW + 2)) == '0;
  endfunction

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            fault_q, fault_d;

  fq_entry_t       head, wdata;
  logic [1:0]      count;
  logic            empty, valid, pop, push, room, attempt, issue;
  logic [2:0]      occ;
  logic [PC_W-1:0] target;
  logic [INST_W-1:0] inst_w;

  assign target = branch_target(br_pc, br_offset);
  assign empty  = (count == 2'd0);

  // A redirect cycle hides the head so a simultaneous ready cannot consume it.
  assign valid = ~rst & ~empty & ~br_valid;
  assign pop   = valid & dec.inst_ready;

  // Space check counts the read already in flight, so the queue cannot overflow.
  assign occ     = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign room    = (occ < 3'(QDEPTH));
  assign attempt = ~rst & ~br_valid & (state_q == S_RUN) & room;
  assign issue   = attempt & in_range(pc_q);

  // The word returning during a redirect or reset belongs to the old stream.
  assign push  = inflight_q & ~br_valid & ~rst;
  assign wdata = '{inst: imem_rdata, pc: req_pc_q};

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_valid),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (br_valid) begin
      pc_d = target;
      case (state_q)
        S_START: state_d = S_RUN;
        S_FAULT: if (in_range(target)) state_d = S_RUN;
        default: ;
      endcase
    end else begin
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 64'd4;
      end
      case (state_q)
        S_START: state_d = S_RUN;
        S_RUN:   if (attempt && !issue) state_d = S_FAULT;
        default: ;
      endcase
    end
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_START;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
    end
  end

  assign inst_w         = (rst | empty) ? '0 : head.inst;
  assign dec.inst       = inst_w;
  assign dec.inst_pc    = (rst | empty) ? '0 : head.pc;
  assign dec.opcode     = inst_w[OPC_MSB:OPC_LSB];
  assign dec.inst_valid = valid;

  assign imem_en   = issue;
  assign imem_addr = issue ? pc_q[IMEM_AW+1:2] : '0;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          AW    = 4;
  localparam int          WORDS = 1 << AW;
  localparam logic [63:0] LIMIT = 64'(4 * WORDS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          br_valid;
  logic [63:0]   br_pc, br_offset;
  logic          fault;
  fetch_state_e  dbg_state;

  fetch_if dec_if ();

  fetch_unit #(.IMEM_AW(AW), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .dec        (dec_if),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // ---------------- instruction ROM ----------------
  logic [31:0] rom [WORDS];
  initial for (int i = 0; i < WORDS; i++) rom[i] = 32'hA000_0000 + 32'(i);
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the PCs of words fetched and waiting for decode, oldest first.
  logic [63:0] exp_q[$];
  logic [63:0] m_pc = 64'h0;
  bit          m_infl = 0;
  logic [63:0] m_infl_pc = 64'h0;
  int          m_mode = 0;   // 0: idle after reset, 1: fetching, 2: parked out of range

  function automatic bit m_valid();
    return !rst && exp_q.size() != 0 && !br_valid;
  endfunction

  function automatic bit m_attempt();
    int occ;
    occ = exp_q.size() - int'(m_valid() && dec_if.inst_ready) + int'(m_infl);
    return !rst && m_mode == 1 && !br_valid && occ < 2;
  endfunction

  function automatic bit m_issue();
    return m_attempt() && m_pc < LIMIT;
  endfunction

  bit          u_pop, u_en, u_att;
  logic [63:0] u_tgt;
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 64'h0; exp_q.delete(); m_infl = 0; m_mode = 0;
    end else begin
      u_pop = m_valid() && dec_if.inst_ready;
      u_en  = m_issue();
      u_att = m_attempt();
      if (br_valid) begin
        u_tgt = br_pc + br_offset * 64'd4;
        exp_q.delete();
        m_infl = 0;
        m_pc = u_tgt;
        if (m_mode == 0 || (m_mode == 2 && u_tgt < LIMIT)) m_mode = 1;
      end else begin
        if (u_pop) void'(exp_q.pop_front());
        if (m_infl) exp_q.push_back(m_infl_pc);
        if (u_en) begin
          m_infl_pc = m_pc; m_pc = m_pc + 64'd4; m_infl = 1;
        end else begin
          m_infl = 0;
        end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && u_att && !u_en) m_mode = 2;
      end
    end
  end

  logic [63:0] e_pc;
  logic [31:0] e_inst;
  logic [3:0]  e_idx;
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst || exp_q.size() == 0) begin
        e_pc = 64'h0; e_inst = 32'h0;
      end else begin
        e_pc = exp_q[0]; e_idx = e_pc[5:2]; e_inst = rom[e_idx];
      end
      chk("m_imem_en", 64'(imem_en), 64'(m_issue()));
      chk("m_imem_addr", 64'(imem_addr), m_issue() ? 64'(m_pc[5:2]) : 64'h0);
      chk("m_inst_valid", 64'(dec_if.inst_valid), 64'(m_valid()));
      chk("m_inst", 64'(dec_if.inst), 64'(e_inst));
      chk("m_inst_pc", dec_if.inst_pc, e_pc);
      chk("m_opcode", 64'(dec_if.opcode), 64'(e_inst >> 21));
      chk("m_fault", 64'(fault), 64'(m_mode == 2));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic drive_step(input bit b_v, input logic [63:0] b_pc, input logic [63:0] b_off,
                            input bit rdy, input bit r);
    @(posedge clk); #1;
    br_valid = b_v; br_pc = b_pc; br_offset = b_off; dec_if.inst_ready = rdy; rst = r;
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  bit found;
  initial begin
    rst = 1'b1; br_valid = 1'b0; br_pc = '0; br_offset = '0; dec_if.inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1;

    // Reset release and first fetches.
    @(negedge clk);
    chk("rst_valid", 64'(dec_if.inst_valid), 0);
    chk("rst_en", 64'(imem_en), 0);
    chk("rst_pc", dec_if.inst_pc, 0);
    chk("rst_opcode", 64'(dec_if.opcode), 0);
    chk("rst_fault", 64'(fault), 0);
    step(); chk("c1_en", 64'(imem_en), 1); chk("c1_addr", 64'(imem_addr), 0);
    chk("c1_valid", 64'(dec_if.inst_valid), 0);
    step(); chk("c2_valid", 64'(dec_if.inst_valid), 0); chk("c2_addr", 64'(imem_addr), 1);
    step(); chk("c3_valid", 64'(dec_if.inst_valid), 1); chk("c3_pc", dec_if.inst_pc, 0);
    chk("c3_inst", 64'(dec_if.inst), 64'hA000_0000); chk("c3_opcode", 64'(dec_if.opcode), 64'h500);
    for (int i = 1; i <= 3; i++) begin
      step(); chk("seq_pc", dec_if.inst_pc, 64'(4 * i));
    end

    // Backpressure: ready low for 5 cycles.
    drive_step(0, 0, 0, 0, 0); chk("bp_head", dec_if.inst_pc, 64'h10);
    step(); chk("bp_full_en", 64'(imem_en), 0); chk("bp_hold_pc", dec_if.inst_pc, 64'h10);
    repeat (3) step();
    chk("bp_still_idle", 64'(imem_en), 0);
    drive_step(0, 0, 0, 1, 0);
    chk("bp_resume_en", 64'(imem_en), 1); chk("bp_resume_addr", 64'(imem_addr), 6);
    chk("bp_resume_pc", dec_if.inst_pc, 64'h10);
    step(); chk("bp_next_pc", dec_if.inst_pc, 64'h14);
    step(); chk("bp_next2_pc", dec_if.inst_pc, 64'h18);

    // Run off the end of the 16-word ROM.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (dec_if.inst_valid && dec_if.inst_pc == 64'h3C) found = 1;
    end
    chk("fault_last_seen", 64'(found), 1);
    step(); chk("fault_set", 64'(fault), 1); chk("fault_no_en", 64'(imem_en), 0);
    chk("fault_drained", 64'(dec_if.inst_valid), 0);
    step(); chk("fault_parked_en", 64'(imem_en), 0);

    // Recover from fault: 0x3C + (-15*4) = 0.
    drive_step(1, 64'h3C, 64'hFFFF_FFFF_FFFF_FFF1, 1, 0);
    chk("rec_t_en", 64'(imem_en), 0); chk("rec_t_fault", 64'(fault), 1);
    drive_step(0, 0, 0, 1, 0);
    chk("rec_t1_fault", 64'(fault), 0); chk("rec_t1_en", 64'(imem_en), 1);
    chk("rec_t1_addr", 64'(imem_addr), 0);
    step(); chk("rec_t2_valid", 64'(dec_if.inst_valid), 0);
    step(); chk("rec_t3_valid", 64'(dec_if.inst_valid), 1); chk("rec_t3_pc", dec_if.inst_pc, 0);
    step(); chk("rec_t4_pc", dec_if.inst_pc, 64'h4);

    // Redirect with ready high and a read in flight: 0x10 + (-2*4) = 8.
    drive_step(1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    chk("br_t_valid", 64'(dec_if.inst_valid), 0); chk("br_t_en", 64'(imem_en), 0);
    drive_step(0, 0, 0, 1, 0);
    chk("br_t1_en", 64'(imem_en), 1); chk("br_t1_addr", 64'(imem_addr), 2);
    step(); chk("br_t2_valid", 64'(dec_if.inst_valid), 0);
    step(); chk("br_t3_valid", 64'(dec_if.inst_valid), 1); chk("br_t3_pc", dec_if.inst_pc, 64'h8);
    chk("br_t3_inst", 64'(dec_if.inst), 64'hA000_0002);
    step(); chk("br_t4_pc", dec_if.inst_pc, 64'hC);

    // Reset mid-stream with decode stalled.
    drive_step(0, 0, 0, 0, 1);
    chk("mr_valid", 64'(dec_if.inst_valid), 0); chk("mr_en", 64'(imem_en), 0);
    chk("mr_inst", 64'(dec_if.inst), 0);
    drive_step(0, 0, 0, 1, 0);
    chk("mr1_valid", 64'(dec_if.inst_valid), 0); chk("mr1_pc", dec_if.inst_pc, 0);
    chk("mr1_opcode", 64'(dec_if.opcode), 0); chk("mr1_en", 64'(imem_en), 0);
    chk("mr1_fault", 64'(fault), 0);
    step(); chk("mr2_en", 64'(imem_en), 1); chk("mr2_addr", 64'(imem_addr), 0);
    step(); chk("mr3_valid", 64'(dec_if.inst_valid), 0);
    step(); chk("mr4_valid", 64'(dec_if.inst_valid), 1); chk("mr4_pc", dec_if.inst_pc, 0);
    step(); chk("mr5_pc", dec_if.inst_pc, 64'h4);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
